// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IF = 2'd1,
        ST_GRANT_D  = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and single-port memory bus of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are held until the matching valid pulse.
// Ports: slave = arbiter view, master = core + memory view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: maps fetch/data requests and the priority bit to a one-hot grant.
// Latency: combinational.
// Backpressure: none; a lone request always wins, prio_d breaks ties.
// Ports: req_if, req_d in; prio_d in (1 = data wins a tie); gnt out ({data, fetch}).
module rr_pick2 (
    input  logic       req_if,
    input  logic       req_d,
    input  logic       prio_d,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_if && req_d) begin
            gnt = prio_d ? 2'b10 : 2'b01;
        end else if (req_d) begin
            gnt = 2'b10;
        end else if (req_if) begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port synchronous memory.
// Latency: grant to valid is 2 cycles; one access per 3 cycles at most.
// Backpressure: requesters hold req until valid; stall tells the core to hold.
// Ports: clk, rst (sync, active-high); bus (fetch/data/memory signals);
//        stall (core hold); conflict_cnt (saturating count of contested grants).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic             stall,
    output logic [CNT_W-1:0] conflict_cnt
);

    state_e            state_q, state_d;
    logic              prio_d_q, prio_d_d;   // 1: data port wins the next tie
    logic              port_d_q, port_d_d;   // in-flight access belongs to the data port
    logic              we_q, we_d;           // in-flight data access is a store
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic              if_valid;
    logic              d_valid;
    logic              elig_if;
    logic              elig_d;
    logic [1:0]        gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Valid pulses come straight from the RESP state, so a reset that lands
    // before RESP drops the pending completion.
    assign if_valid = (state_q == ST_RESP) && !port_d_q;
    assign d_valid  = (state_q == ST_RESP) &&  port_d_q;

    // A port whose valid is high this cycle has just been served; its req
    // only counts again from the next cycle.
    assign elig_if = bus.if_req && !if_valid;
    assign elig_d  = bus.d_req  && !d_valid;

    rr_pick2 u_pick (
        .req_if (elig_if),
        .req_d  (elig_d),
        .prio_d (prio_d_q),
        .gnt    (gnt)
    );

    always_comb begin
        state_d        = state_q;
        prio_d_d       = prio_d_q;
        port_d_d       = port_d_q;
        we_d           = we_q;
        if_rdata_d     = if_rdata_q;
        d_rdata_d      = d_rdata_q;
        conflict_cnt_d = conflict_cnt_q;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                // No new access is launched while reset is held.
                if (!rst && (gnt != 2'b00)) begin
                    mem_en = 1'b1;
                    if (gnt[1]) begin
                        mem_we    = bus.d_we;
                        mem_addr  = bus.d_addr;
                        mem_wdata = bus.d_we ? bus.d_wdata : '0;
                        we_d      = bus.d_we;
                        port_d_d  = 1'b1;
                        prio_d_d  = 1'b0;
                        state_d   = ST_GRANT_D;
                    end else begin
                        mem_addr  = bus.if_addr;
                        we_d      = 1'b0;
                        port_d_d  = 1'b0;
                        prio_d_d  = 1'b1;
                        state_d   = ST_GRANT_IF;
                    end
                    if (elig_if && elig_d) begin
                        conflict_cnt_d = sat_inc(conflict_cnt_q);
                    end
                end
            end
            ST_GRANT_IF: begin
                if_rdata_d = bus.mem_rdata;
                state_d    = ST_RESP;
            end
            ST_GRANT_D: begin
                // Stores leave d_rdata untouched.
                if (!we_q) begin
                    d_rdata_d = bus.mem_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            prio_d_q       <= 1'b1;
            port_d_q       <= 1'b0;
            we_q           <= 1'b0;
            if_rdata_q     <= '0;
            d_rdata_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            prio_d_q       <= prio_d_d;
            port_d_q       <= port_d_d;
            we_q           <= we_d;
            if_rdata_q     <= if_rdata_d;
            d_rdata_q      <= d_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    assign stall        = (bus.if_req && !if_valid) || (bus.d_req && !d_valid);
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run.
// Latency: n/a.
// Backpressure: the bench's core model holds each request until its valid.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic [CNT_W-1:0] conflict_cnt;
    int               tests = 0;
    int               fails = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall        (stall),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b ^ 8'hA5, 8'h3C, ~b, b};
    endfunction

    // Single-port synchronous memory: read data one cycle after the strobe.
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem[4] = 32'h00500093;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata     <= mem[bus.mem_addr];
            end
        end
    end

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle_inputs(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we} !== 4'b0) begin fails++; $display("FAIL rst_strobes got=%b exp=0000", {bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we}); end
        tests++; if ({bus.mem_addr, bus.mem_wdata} !== '0) begin fails++; $display("FAIL rst_mem_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata}); end
        tests++; if (bus.if_rdata !== 32'h0) begin fails++; $display("FAIL rst_if_rdata got=%h exp=0", bus.if_rdata); end
        tests++; if (bus.d_rdata !== 32'h0) begin fails++; $display("FAIL rst_d_rdata got=%h exp=0", bus.d_rdata); end
        tests++; if (conflict_cnt !== 16'h0) begin fails++; $display("FAIL rst_conflict_cnt got=%h exp=0", conflict_cnt); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%b exp=0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_lone_fetch();
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 8'h04; #1;
        tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h04}) begin fails++; $display("FAIL lf_grant got=%b/%b/%h exp=1/0/04", bus.mem_en, bus.mem_we, bus.mem_addr); end
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lf_stall_c0 got=%b exp=1", stall); end
        @(negedge clk); #1;
        tests++; if ({bus.mem_en, bus.if_valid, stall} !== 3'b001) begin fails++; $display("FAIL lf_c1 en/valid/stall got=%b exp=001", {bus.mem_en, bus.if_valid, stall}); end
        @(negedge clk); #1;
        tests++; if ({bus.if_valid, stall} !== 2'b10) begin fails++; $display("FAIL lf_c2 valid/stall got=%b exp=10", {bus.if_valid, stall}); end
        tests++; if (bus.if_rdata !== 32'h00500093) begin fails++; $display("FAIL lf_rdata got=%h exp=00500093", bus.if_rdata); end
        @(negedge clk); bus.if_req = 1'b0; #1;
        tests++; if ({bus.if_valid, bus.if_rdata} !== {1'b0, 32'h00500093}) begin fails++; $display("FAIL lf_hold got=%b/%h exp=0/00500093", bus.if_valid, bus.if_rdata); end
    endtask

    task automatic test_store_load();
        int we_pulses = 0;
        @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 32'hDEADBEEF; #1;
        tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 8'h20, 32'hDEADBEEF}) begin fails++; $display("FAIL sl_store_grant got=%b/%b/%h/%h exp=1/1/20/deadbeef", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c == 3) bus.d_we = 1'b0;
                if (c == 6) bus.d_req = 1'b0;
                #1;
            end
            if (bus.mem_en && bus.mem_we) we_pulses++;
            if (c == 2) begin
                tests++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL sl_store_done valid/rdata got=%b/%h exp=1/0", bus.d_valid, bus.d_rdata); end
            end
            if (c == 3) begin
                tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h20}) begin fails++; $display("FAIL sl_load_grant got=%b/%b/%h exp=1/0/20", bus.mem_en, bus.mem_we, bus.mem_addr); end
            end
            if (c == 5) begin
                tests++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL sl_load_done valid/rdata got=%b/%h exp=1/deadbeef", bus.d_valid, bus.d_rdata); end
            end
        end
        tests++; if (we_pulses != 1) begin fails++; $display("FAIL sl_we_pulses got=%0d exp=1", we_pulses); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h08;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10; #1;
        tests++; if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin fails++; $display("FAIL sim_first_grant got=%b/%b/%h exp=1/0/10", bus.mem_en, bus.mem_we, bus.mem_addr); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        tests++; if ({bus.d_valid, bus.if_valid, bus.d_rdata} !== {2'b10, init_word(8'h10)}) begin fails++; $display("FAIL sim_d_done got=%b%b/%h exp=10/%h", bus.d_valid, bus.if_valid, bus.d_rdata, init_word(8'h10)); end
        @(negedge clk); bus.d_req = 1'b0; #1;
        tests++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 8'h08}) begin fails++; $display("FAIL sim_second_grant got=%b/%h exp=1/08", bus.mem_en, bus.mem_addr); end
        @(negedge clk); #1;
        tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL sim_if_early got=%b exp=0", bus.if_valid); end
        @(negedge clk); #1;
        tests++; if ({bus.if_valid, bus.if_rdata} !== {1'b1, init_word(8'h08)}) begin fails++; $display("FAIL sim_if_done got=%b/%h exp=1/%h", bus.if_valid, bus.if_rdata, init_word(8'h08)); end
        @(negedge clk); bus.if_req = 1'b0; #1;
        tests++; if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL sim_conflict_cnt got=%0d exp=1", conflict_cnt); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_addr [4];
        exp_addr = '{8'h22, 8'h11, 8'h22, 8'h11};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 8'h11;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h22; #1;
            if (c % 3 == 0) begin
                tests++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, exp_addr[c/3]}) begin fails++; $display("FAIL fair_grant c=%0d got=%b/%h exp=1/%h", c, bus.mem_en, bus.mem_addr, exp_addr[c/3]); end
            end else begin
                tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL fair_idle_bus c=%0d got=%b exp=0", c, bus.mem_en); end
            end
            if (c % 3 == 2) begin
                tests++; if ({bus.if_valid, bus.d_valid} !== (((c / 3) % 2 == 0) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL fair_valid c=%0d got=%b%b", c, bus.if_valid, bus.d_valid); end
            end
        end
        @(negedge clk); idle_inputs(); #1;
        tests++; if (conflict_cnt !== 16'd4) begin fails++; $display("FAIL fair_conflict_cnt got=%0d exp=4", conflict_cnt); end
    endtask

    task automatic test_reset_mid();
        int d_pulses = 0;
        @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        @(negedge clk); rst = 1'b1; bus.d_req = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        tests++; if ({bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, stall} !== '0) begin fails++; $display("FAIL rm_strobes_zero got=%b%b%b%b/%h/%h/%b", bus.if_valid, bus.d_valid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, stall); end
        tests++; if ({bus.if_rdata, bus.d_rdata, conflict_cnt} !== '0) begin fails++; $display("FAIL rm_regs_zero got=%h/%h/%h exp=0", bus.if_rdata, bus.d_rdata, conflict_cnt); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (bus.d_valid) d_pulses++;
        end
        tests++; if (d_pulses != 0) begin fails++; $display("FAIL rm_no_d_valid got=%0d exp=0", d_pulses); end
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 8'h04; #1;
        tests++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 8'h04}) begin fails++; $display("FAIL rm_fetch_grant got=%b/%h exp=1/04", bus.mem_en, bus.mem_addr); end
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({bus.if_valid, bus.if_rdata} !== {1'b1, 32'h00500093}) begin fails++; $display("FAIL rm_fetch_done got=%b/%h exp=1/00500093", bus.if_valid, bus.if_rdata); end
        @(negedge clk); bus.if_req = 1'b0;
    endtask

    // Transaction-level model: fetches live in 0x40-0x7F (never stored to),
    // data accesses in 0x80-0xFF; each port is served in order, so a plain
    // array updated on each store completion predicts every read.
    task automatic test_random();
        logic [DW-1:0] model [256];
        logic [DW-1:0] last_load = '0;
        logic [DW-1:0] d_wd = '0;
        logic [7:0]    if_a = '0, d_a = '0;
        bit            if_act = 0, d_act = 0, d_w = 0;
        int            if_start = 0, d_start = 0;
        int            n_if = 0, n_if_done = 0, n_d = 0, n_d_done = 0, n_st = 0, we_seen = 0;
        for (int i = 0; i < 256; i++) model[i] = init_word(i);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!if_act && c < 360 && $urandom_range(0, 2) == 0) begin
                if_act = 1; if_start = c; n_if++;
                if_a = 8'h40 + 8'($urandom_range(0, 63));
            end
            if (!d_act && c < 360 && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_start = c; n_d++;
                d_a = 8'h80 + 8'($urandom_range(0, 127));
                d_w = ($urandom_range(0, 1) == 1);
                d_wd = $urandom;
                if (d_w) n_st++;
            end
            bus.if_req = if_act; bus.if_addr = if_a;
            bus.d_req = d_act; bus.d_we = d_w; bus.d_addr = d_a; bus.d_wdata = d_wd;
            #1;
            tests++; if (stall !== ((if_act && !bus.if_valid) || (d_act && !bus.d_valid))) begin fails++; $display("FAIL rnd_stall c=%0d got=%b", c, stall); end
            if (!bus.mem_en) begin
                tests++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin fails++; $display("FAIL rnd_bus_quiet c=%0d got=%b/%h/%h exp=0", c, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
            end else if (bus.mem_we) begin
                we_seen++;
                tests++; if (!(d_act && d_w) || bus.mem_addr !== d_a || bus.mem_wdata !== d_wd) begin fails++; $display("FAIL rnd_write c=%0d got=%h/%h exp=%h/%h", c, bus.mem_addr, bus.mem_wdata, d_a, d_wd); end
            end
            if (bus.if_valid) begin
                tests++; if (!if_act || (c - if_start) < 2 || (c - if_start) > 5) begin fails++; $display("FAIL rnd_if_latency c=%0d got=%0d exp=2..5", c, c - if_start); end
                tests++; if (bus.if_rdata !== model[if_a]) begin fails++; $display("FAIL rnd_if_rdata got=%h exp=%h", bus.if_rdata, model[if_a]); end
                if_act = 0; n_if_done++;
            end else if (if_act && (c - if_start) > 8) begin
                tests++; fails++; $display("FAIL rnd_if_timeout got=none exp=if_valid by 5 cycles");
                if_act = 0;
            end
            if (bus.d_valid) begin
                tests++; if (!d_act || (c - d_start) < 2 || (c - d_start) > 5) begin fails++; $display("FAIL rnd_d_latency c=%0d got=%0d exp=2..5", c, c - d_start); end
                if (d_w) model[d_a] = d_wd;
                else last_load = model[d_a];
                tests++; if (bus.d_rdata !== last_load) begin fails++; $display("FAIL rnd_d_rdata we=%b got=%h exp=%h", d_w, bus.d_rdata, last_load); end
                d_act = 0; n_d_done++;
            end else if (d_act && (c - d_start) > 8) begin
                tests++; fails++; $display("FAIL rnd_d_timeout got=none exp=d_valid by 5 cycles");
                d_act = 0;
            end
        end
        @(negedge clk); idle_inputs();
        tests++; if (n_if_done != n_if || n_d_done != n_d) begin fails++; $display("FAIL rnd_completions got=%0d/%0d exp=%0d/%0d", n_if_done, n_d_done, n_if, n_d); end
        tests++; if (we_seen != n_st) begin fails++; $display("FAIL rnd_we_pulses got=%0d exp=%0d", we_seen, n_st); end
    endtask

    // Reaching 0xFFFF naturally takes ~200k cycles, so the counter is preset
    // close to the top and then driven through contested grants.
    task automatic test_saturation();
        int exp_cnt = 16'hFFFD;
        do_reset();
        @(negedge clk);
        force dut.conflict_cnt_q = 16'hFFFD;
        #1;
        release dut.conflict_cnt_q;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.if_req = 1'b1; bus.if_addr = 8'h01;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h02; #1;
            if (c % 3 == 1) begin
                if (exp_cnt < 16'hFFFF) exp_cnt = exp_cnt + 1;
                tests++; if (conflict_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL sat_cnt c=%0d got=%h exp=%h", c, conflict_cnt, 16'(exp_cnt)); end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
        test_random();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width shared by both ports and memory.
REQ-002 Parameter: DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 if_req  input  1  instruction fetch request; held high until if_valid.
REQ-006 if_addr  input  ADDR_W  fetch word address; stable while if_req is high.
REQ-007 if_rdata  output  DATA_W  fetched instruction word; valid when if_valid=1.
REQ-008 if_valid  output  1  one-cycle completion pulse for a fetch.
REQ-009 d_req  input  1  data access request; held high until d_valid.
REQ-010 d_we  input  1  1=store, 0=load; stable while d_req is high.
REQ-011 d_addr  input  ADDR_W  data word address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_rdata  output  DATA_W  load data; valid when d_valid=1.
REQ-014 d_valid  output  1  one-cycle completion pulse for a load or store.
REQ-015 mem_en  output  1  memory access strobe, single-port memory.
REQ-016 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-017 mem_addr  output  ADDR_W  memory word address.
REQ-018 mem_wdata  output  DATA_W  memory write data.
REQ-019 mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after a read strobe.
REQ-020 stall  output  1  core hold: (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
REQ-021 conflict_cnt  output  16  count of cycles in which a grant was made with both requests pending.

Function
REQ-022 FSM states: IDLE, GRANT_IF, GRANT_D, RESP. Exactly one is active.
REQ-023 IDLE: if no eligible request, stay in IDLE and drive mem_en=0. Otherwise grant one requester, drive mem_en=1 with its address, we and wdata in that cycle, and go to GRANT_IF or GRANT_D.
REQ-024 Arbitration: a single eligible request is granted. Both eligible: grant the port not granted last (1-bit round-robin pointer); after reset the pointer favours the data port.
REQ-025 GRANT_x: mem_en=0. Capture mem_rdata into the matching rdata register (loads and fetches only). Go to RESP.
REQ-026 RESP: assert the matching valid for exactly this cycle, then return to IDLE. Grant-to-valid latency is fixed at 2 cycles; maximum throughput is one access per 3 cycles.
REQ-027 Eligibility: a requester whose valid is high in the current cycle is not eligible; its request is considered again from the next cycle.
REQ-028 Stores: the write occurs in the grant cycle. d_valid pulses in RESP. d_rdata holds its previous value.
REQ-029 if_rdata and d_rdata hold their last captured value until overwritten; if_we is not a port, and mem_we is never 1 on a fetch grant.
REQ-030 conflict_cnt increments by 1 in each IDLE grant cycle with if_req & d_req both eligible; it saturates at 0xFFFF, with no wrap.
REQ-031 mem_addr, mem_we and mem_wdata are 0 whenever mem_en=0.
REQ-032 A request dropped before its valid (protocol violation) still completes; the valid pulse is still issued.

Reset
REQ-033 While rst=1, at the clock edge: FSM goes to IDLE; if_valid, d_valid, mem_en and mem_we are 0; if_rdata, d_rdata and conflict_cnt are 0; the round-robin pointer favours data.
REQ-034 Reset mid-transaction abandons the access: no valid pulse is issued for it, and an in-flight write already strobed is not retracted.

Structure
REQ-035 Shared package holds the FSM state enum, ADDR_W/DATA_W defaults and the 16-bit counter width constant.
REQ-036 The round-robin choice is a natural sub-module, rr_pick2, which maps two requests and the pointer to a one-hot grant. Everything else stays in mem_arbiter.

Verification
REQ-037 Lone fetch: if_req=1, if_addr=0x04 with mem holding 0x00500093 -> mem_en at cycle 0, if_valid at cycle 2, if_rdata=0x00500093, stall=1 for cycles 0-1.
REQ-038 Simultaneous requests after reset: fetch at 0x08, load at 0x10 -> data granted first (d_valid at cycle 2), fetch granted at cycle 3 (if_valid at cycle 5), conflict_cnt=1.
REQ-039 Store then load: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, then a load from 0x20 -> d_rdata=0xDEADBEEF, with exactly one mem_we pulse.
REQ-040 Fairness: both requests held continuously for 12 cycles -> grants alternate D, IF, D, IF, and conflict_cnt=4.
REQ-041 Reset mid-operation: rst asserted in a GRANT_D cycle -> no d_valid is issued, all outputs are 0 the next cycle, and a following fetch completes normally.
REQ-042 Saturation: force 65536 conflicted grants -> conflict_cnt stays at 0xFFFF.
